// File: rtl/resp_demux2_pe_if.sv
// Single response-beat bundle (valid, opc, rdata, ID).
// master drives the beat and slave receives it. There is no ready: the stream is never throttled.
interface resp_demux2_pe_if #(
    parameter int ID_WIDTH   = 20,
    parameter int DATA_WIDTH = 32
);
    logic                  valid;
    logic                  opc;
    logic [DATA_WIDTH-1:0] rdata;
    logic [ID_WIDTH-1:0]   ID;

    modport master (output valid, output opc, output rdata, output ID);
    modport slave  (input  valid, input  opc, input  rdata, input  ID);
endinterface

// File: rtl/resp_demux2_pe.sv
// Routes the slave response stream to CH0/CH1 by an ID bit, with per-channel outstanding counters.
// Latency 1 cycle (registered outputs). No backpressure: one beat is accepted every cycle.
module resp_demux2_pe #(
    parameter  int ID_WIDTH   = 20,
    parameter  int DATA_WIDTH = 32,
    parameter  int ROUTE_BIT  = 0,
    parameter  int MAX_OUTST  = 4,
    localparam int CNT_W      = $clog2(MAX_OUTST + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_gnt_CH0_i,
    input  logic               req_gnt_CH1_i,
    resp_demux2_pe_if.slave    data_r_i,
    resp_demux2_pe_if.master   data_r_CH0_o,
    resp_demux2_pe_if.master   data_r_CH1_o,
    output logic [CNT_W-1:0]   outst_CH0_o,
    output logic [CNT_W-1:0]   outst_CH1_o,
    input  logic               err_clr_i,
    output logic [1:0]         err_unexp_o,
    output logic [1:0]         err_ovf_o
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

    typedef struct packed {
        logic                  opc;
        logic [DATA_WIDTH-1:0] rdata;
        logic [ID_WIDTH-1:0]   id;
    } beat_t;

    logic                 sel;
    logic [1:0]           inc;
    logic [1:0]           dec;
    logic [1:0]           vld_q, vld_d;
    beat_t [1:0]          beat_q, beat_d;
    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]           unexp_q, unexp_d;
    logic [1:0]           ovf_q, ovf_d;

    always_comb begin
        sel     = data_r_i.ID[ROUTE_BIT];
        inc     = {req_gnt_CH1_i, req_gnt_CH0_i};
        dec     = {data_r_i.valid & sel, data_r_i.valid & ~sel};
        vld_d   = dec;
        beat_d  = beat_q;
        cnt_d   = cnt_q;
        // Clear first, then OR in this cycle's set conditions, so a set wins over a clear.
        unexp_d = err_clr_i ? 2'b00 : unexp_q;
        ovf_d   = err_clr_i ? 2'b00 : ovf_q;
        for (int x = 0; x < 2; x++) begin
            if (dec[x]) begin
                beat_d[x].opc   = data_r_i.opc;
                beat_d[x].rdata = data_r_i.rdata;
                beat_d[x].id    = data_r_i.ID;
            end
            if (inc[x] && !dec[x]) begin
                if (cnt_q[x] == MAX_CNT) ovf_d[x] = 1'b1;
                else                     cnt_d[x] = cnt_q[x] + CNT_W'(1);
            end else if (dec[x] && !inc[x]) begin
                // The response is still forwarded even though no grant was outstanding.
                if (cnt_q[x] == '0) unexp_d[x] = 1'b1;
                else                cnt_d[x]   = cnt_q[x] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= '0;
            beat_q  <= '0;
            cnt_q   <= '0;
            unexp_q <= '0;
            ovf_q   <= '0;
        end else begin
            vld_q   <= vld_d;
            beat_q  <= beat_d;
            cnt_q   <= cnt_d;
            unexp_q <= unexp_d;
            ovf_q   <= ovf_d;
        end
    end

    assign data_r_CH0_o.valid = vld_q[0];
    assign data_r_CH0_o.opc   = beat_q[0].opc;
    assign data_r_CH0_o.rdata = beat_q[0].rdata;
    assign data_r_CH0_o.ID    = beat_q[0].id;
    assign data_r_CH1_o.valid = vld_q[1];
    assign data_r_CH1_o.opc   = beat_q[1].opc;
    assign data_r_CH1_o.rdata = beat_q[1].rdata;
    assign data_r_CH1_o.ID    = beat_q[1].id;
    assign outst_CH0_o        = cnt_q[0];
    assign outst_CH1_o        = cnt_q[1];
    assign err_unexp_o        = unexp_q;
    assign err_ovf_o          = ovf_q;
endmodule
